// File: rtl/alu_logic_issue.sv
// ---------------------------------------------------------------------------
// alu_logic_issue
//
// Command issue stage feeding the 8-bit logical unit of the New_Alu datapath.
// Commands {a, b, op} enter through a valid/ready port into a small FIFO.
// A two-state controller pops the FIFO head into a registered issue slot that
// drives the logical unit (operands, select, active-low enable). While the
// unit is enabled its combinational result is captured into a registered
// result slot with valid/ready handshake and status flags.
//
// Parameters:
//   DEPTH  command FIFO entries (power of two, 2..16)
//   PTR_W  FIFO pointer width, log2(DEPTH)
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   cmd_valid_in/ready_out    command handshake
//   cmd_a_in, cmd_b_in        operands
//   cmd_op_in                 logical-unit select code
//   lu_a_out, lu_b_out        operands to the logical unit
//   lu_s_out                  select to the logical unit
//   lu_en_out                 active-low enable to the logical unit
//   lu_y_in                   result from the logical unit
//   res_valid_out/ready_in    result handshake
//   res_y_out, res_op_out     captured result and its op code
//   res_zero_out              captured result is zero
//   res_illegal_out           op code was 3'b011 or 3'b100
//   res_parity_out            XOR reduction of the captured result
//                             (present only when ALU_PARITY_EN is defined)
//   fifo_count_out            FIFO occupancy, 0..DEPTH
//
// Build option:
//   ALU_PARITY_EN  adds res_parity_out and its register.
// ---------------------------------------------------------------------------
// state  | meaning
// IDLE   | issue slot empty, logical unit disabled (lu_en_out = 1)
// ISSUE  | issue slot holds a command, unit enabled (lu_en_out = 0),
//        | lu_y_in is valid and captured when the result slot allows it
// ---------------------------------------------------------------------------
module alu_logic_issue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [7:0]       cmd_a_in,
    input  logic [7:0]       cmd_b_in,
    input  logic [2:0]       cmd_op_in,
    output logic [7:0]       lu_a_out,
    output logic [7:0]       lu_b_out,
    output logic [2:0]       lu_s_out,
    output logic             lu_en_out,
    input  logic [7:0]       lu_y_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [7:0]       res_y_out,
    output logic [2:0]       res_op_out,
    output logic             res_zero_out,
    output logic             res_illegal_out,
`ifdef ALU_PARITY_EN
    output logic             res_parity_out,
`endif
    output logic [PTR_W:0]   fifo_count_out
);

    localparam int             ENTRY_W    = 19;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    localparam logic [2:0] OP_ILLEGAL_A = 3'b011;
    localparam logic [2:0] OP_ILLEGAL_B = 3'b100;

    // -----------------------------------------------------------------------
    // Declarations
    // -----------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               cmd_push;
    logic               fifo_pop;
    logic               capture;
    logic [ENTRY_W-1:0] cmd_entry;
    logic [ENTRY_W-1:0] fifo_head;

    logic [0:0]         state_q, state_d;

    logic [7:0]         lu_a_q, lu_a_d;
    logic [7:0]         lu_b_q, lu_b_d;
    logic [2:0]         lu_s_q, lu_s_d;

    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_y_q, res_y_d;
    logic [2:0]         res_op_q, res_op_d;
    logic               res_zero_q, res_zero_d;
    logic               res_illegal_q, res_illegal_d;
`ifdef ALU_PARITY_EN
    logic               res_parity_q, res_parity_d;
`endif

    // -----------------------------------------------------------------------
    // Handshake decode
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_full  = (count_q == FULL_COUNT);
        fifo_empty = (count_q == '0);
        cmd_push   = cmd_valid_in && !fifo_full;
        cmd_entry  = {cmd_a_in, cmd_b_in, cmd_op_in};
        fifo_head  = fifo_mem_q[rd_ptr_q];

        // The result slot accepts a new value when it is empty or is being
        // drained on this same edge.
        capture    = (state_q == ST_ISSUE) && (!res_valid_q || res_ready_in);

        // The issue slot is refilled whenever it is empty or is being
        // vacated by a capture, giving one result per clock when streaming.
        fifo_pop   = !fifo_empty && ((state_q == ST_IDLE) || capture);
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Pointer width equals log2(DEPTH), so the increment wraps naturally.
        if (cmd_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({cmd_push, fifo_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Issue controller
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_pop) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (capture && !fifo_pop) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Issue slot: operands are held unchanged while stalled and after the
    // slot empties; they only move when a new command is popped.
    // -----------------------------------------------------------------------
    always_comb begin
        lu_a_d = lu_a_q;
        lu_b_d = lu_b_q;
        lu_s_d = lu_s_q;
        if (fifo_pop) begin
            lu_a_d = fifo_head[18:11];
            lu_b_d = fifo_head[10:3];
            lu_s_d = fifo_head[2:0];
        end
    end

    // -----------------------------------------------------------------------
    // Result slot: data and flags are registered together; after a drain
    // only the valid bit drops, data keeps its last value.
    // -----------------------------------------------------------------------
    always_comb begin
        res_valid_d   = res_valid_q;
        res_y_d       = res_y_q;
        res_op_d      = res_op_q;
        res_zero_d    = res_zero_q;
        res_illegal_d = res_illegal_q;
`ifdef ALU_PARITY_EN
        res_parity_d  = res_parity_q;
`endif
        if (capture) begin
            res_valid_d   = 1'b1;
            res_y_d       = lu_y_in;
            res_op_d      = lu_s_q;
            res_zero_d    = (lu_y_in == 8'h00);
            res_illegal_d = (lu_s_q == OP_ILLEGAL_A) || (lu_s_q == OP_ILLEGAL_B);
`ifdef ALU_PARITY_EN
            res_parity_d  = ^lu_y_in;
`endif
        end else if (res_valid_q && res_ready_in) begin
            res_valid_d   = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage; contents are qualified by the pointers and need no reset.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (cmd_push) begin
            fifo_mem_q[wr_ptr_q] <= cmd_entry;
        end
    end

    // -----------------------------------------------------------------------
    // Control and datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= ST_IDLE;
            lu_a_q        <= '0;
            lu_b_q        <= '0;
            lu_s_q        <= '0;
            res_valid_q   <= 1'b0;
            res_y_q       <= '0;
            res_op_q      <= '0;
            res_zero_q    <= 1'b0;
            res_illegal_q <= 1'b0;
`ifdef ALU_PARITY_EN
            res_parity_q  <= 1'b0;
`endif
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            lu_a_q        <= lu_a_d;
            lu_b_q        <= lu_b_d;
            lu_s_q        <= lu_s_d;
            res_valid_q   <= res_valid_d;
            res_y_q       <= res_y_d;
            res_op_q      <= res_op_d;
            res_zero_q    <= res_zero_d;
            res_illegal_q <= res_illegal_d;
`ifdef ALU_PARITY_EN
            res_parity_q  <= res_parity_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cmd_ready_out   = !fifo_full;
    assign fifo_count_out  = count_q;
    assign lu_a_out        = lu_a_q;
    assign lu_b_out        = lu_b_q;
    assign lu_s_out        = lu_s_q;
    assign lu_en_out       = (state_q == ST_IDLE);
    assign res_valid_out   = res_valid_q;
    assign res_y_out       = res_y_q;
    assign res_op_out      = res_op_q;
    assign res_zero_out    = res_zero_q;
    assign res_illegal_out = res_illegal_q;
`ifdef ALU_PARITY_EN
    assign res_parity_out  = res_parity_q;
`endif

endmodule

// File: tb/tb_alu_logic_issue.sv
// Bench for alu_logic_issue: directed scenarios with literal expectations,
// then a randomized run, with a queue-based model compared every cycle.
module tb_alu_logic_issue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_a = '0;
    logic [7:0]       cmd_b = '0;
    logic [2:0]       cmd_op = '0;
    logic [7:0]       lu_a;
    logic [7:0]       lu_b;
    logic [2:0]       lu_s;
    logic             lu_en;
    logic [7:0]       lu_y;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [7:0]       res_y;
    logic [2:0]       res_op;
    logic             res_zero;
    logic             res_illegal;
    logic [PTR_W:0]   fifo_count;
`ifdef ALU_PARITY_EN
    logic             res_parity;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    alu_logic_issue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .cmd_valid_in    (cmd_valid),
        .cmd_ready_out   (cmd_ready),
        .cmd_a_in        (cmd_a),
        .cmd_b_in        (cmd_b),
        .cmd_op_in       (cmd_op),
        .lu_a_out        (lu_a),
        .lu_b_out        (lu_b),
        .lu_s_out        (lu_s),
        .lu_en_out       (lu_en),
        .lu_y_in         (lu_y),
        .res_valid_out   (res_valid),
        .res_ready_in    (res_ready),
        .res_y_out       (res_y),
        .res_op_out      (res_op),
        .res_zero_out    (res_zero),
        .res_illegal_out (res_illegal),
`ifdef ALU_PARITY_EN
        .res_parity_out  (res_parity),
`endif
        .fifo_count_out  (fifo_count)
    );

    always #5 clk = ~clk;

    // Logical unit: NAND, AND, XOR, -, -, NOR, OR, XNOR; codes 011/100 give 0.
    function automatic logic [7:0] lu_func(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            3'b000:  return ~(a & b);
            3'b001:  return a & b;
            3'b010:  return a ^ b;
            3'b101:  return ~(a | b);
            3'b110:  return a | b;
            3'b111:  return ~(a ^ b);
            default: return 8'h00;
        endcase
    endfunction

    // While disabled the unit output is junk so that sampling it is visible.
    logic [7:0] junk = 8'h5A;
    always @(negedge clk) junk = 8'($urandom);
    assign lu_y = lu_en ? junk : lu_func(lu_s, lu_a, lu_b);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    cmd_t       m_fifo[$];
    bit         m_iss_v = 0;
    cmd_t       m_iss = '0;
    bit         m_res_v = 0;
    logic [7:0] m_res_y = '0;
    logic [2:0] m_res_op = '0;
    bit         m_res_zero = 0, m_res_ill = 0, m_res_par = 0;
    bit         m_live = 0;
    bit         m_cap, m_acc;
    logic [7:0] m_y;

    always @(posedge clk) begin
        if (rst) begin
            m_fifo.delete();
            m_iss_v = 0; m_iss = '0;
            m_res_v = 0; m_res_y = '0; m_res_op = '0;
            m_res_zero = 0; m_res_ill = 0; m_res_par = 0;
            m_live = 1;
        end else if (m_live) begin
            m_cap = m_iss_v && (!m_res_v || res_ready);
            m_acc = cmd_valid && (m_fifo.size() < DEPTH);
            if (m_cap) begin
                m_y        = lu_func(m_iss.op, m_iss.a, m_iss.b);
                m_res_v    = 1;
                m_res_y    = m_y;
                m_res_op   = m_iss.op;
                m_res_zero = (m_y == 0);
                m_res_ill  = (m_iss.op == 3 || m_iss.op == 4);
                m_res_par  = ^m_y;
            end else if (m_res_v && res_ready) begin
                m_res_v = 0;
            end
            if (m_fifo.size() > 0 && (!m_iss_v || m_cap)) begin
                m_iss   = m_fifo.pop_front();
                m_iss_v = 1;
            end else if (m_cap) begin
                m_iss_v = 0;
            end
            if (m_acc) m_fifo.push_back(cmd_t'({cmd_a, cmd_b, cmd_op}));
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmd_ready",   32'(cmd_ready),   32'(m_fifo.size() < DEPTH));
            chk("fifo_count",  32'(fifo_count),  32'(m_fifo.size()));
            chk("lu_en",       32'(lu_en),       32'(!m_iss_v));
            chk("lu_a",        32'(lu_a),        32'(m_iss.a));
            chk("lu_b",        32'(lu_b),        32'(m_iss.b));
            chk("lu_s",        32'(lu_s),        32'(m_iss.op));
            chk("res_valid",   32'(res_valid),   32'(m_res_v));
            chk("res_y",       32'(res_y),       32'(m_res_y));
            chk("res_op",      32'(res_op),      32'(m_res_op));
            chk("res_zero",    32'(res_zero),    32'(m_res_zero));
            chk("res_illegal", 32'(res_illegal), 32'(m_res_ill));
`ifdef ALU_PARITY_EN
            chk("res_parity",  32'(res_parity),  32'(m_res_par));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    logic [7:0] got_y[$];
    bit         got_z[$];
    int         got_c[$];

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic rec();
        if (res_valid && res_ready) begin
            got_y.push_back(res_y);
            got_z.push_back(res_zero);
            got_c.push_back(cyc);
        end
    endtask

    task automatic clear_got();
        got_y.delete(); got_z.delete(); got_c.delete();
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = 0;
        step();
        rst = 0;
    endtask

    task automatic drain();
        cmd_valid = 0; res_ready = 1;
        for (int i = 0; i < 12; i++) step();
    endtask

    // Push one command into an idle stage and stop at the edge where the
    // result becomes valid (two edges after the push edge).
    task automatic single(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        cmd_valid = 1; cmd_a = a; cmd_b = b; cmd_op = op; res_ready = 1;
        step();
        cmd_valid = 0;
        step();
        step();
    endtask

    logic [2:0] ops4 [4];
    logic [7:0] exp4 [4];
    bit         expz4[4];
    int         n_acc;
    bit         pre;

    initial begin
        ops4  = '{3'b000, 3'b001, 3'b101, 3'b110};
        exp4  = '{8'hFF, 8'h00, 8'h00, 8'hFF};
        expz4 = '{1'b0, 1'b1, 1'b1, 1'b0};

        // ---- reset values and single-command latency ----
        rst = 1;
        step();
        rst = 0;
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_count",     32'(fifo_count), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_lu_en",     32'(lu_en), 1);
        chk("rst_lu_a",      32'(lu_a), 0);

        cmd_valid = 1; cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_op = 3'b010; res_ready = 1;
        step();
        cmd_valid = 0;
        chk("t1_en_n",  32'(lu_en), 1);
        step();
        chk("t1_en_n1", 32'(lu_en), 0);
        chk("t1_rv_n1", 32'(res_valid), 0);
        step();
        chk("t1_en_n2", 32'(lu_en), 1);
        chk("t1_rv_n2", 32'(res_valid), 1);
        chk("t1_y",     32'(res_y), 32'h CC);
        chk("t1_zero",  32'(res_zero), 0);
        chk("t1_ill",   32'(res_illegal), 0);
        step();
        chk("t1_drained", 32'(res_valid), 0);
        chk("t1_y_held",  32'(res_y), 32'h CC);
        drain();

        // ---- four back-to-back commands ----
        clear_got();
        res_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (i < 4) begin
                cmd_valid = 1; cmd_a = 8'hAA; cmd_b = 8'h55; cmd_op = ops4[i];
            end else begin
                cmd_valid = 0;
            end
            step();
            rec();
        end
        chk("t2_n", 32'(got_y.size()), 4);
        for (int k = 0; k < 4 && k < got_y.size(); k++) begin
            chk($sformatf("t2_y%0d", k), 32'(got_y[k]), 32'(exp4[k]));
            chk($sformatf("t2_z%0d", k), 32'(got_z[k]), 32'(expz4[k]));
            chk($sformatf("t2_cyc%0d", k), 32'(got_c[k] - got_c[0]), 32'(k));
        end
        drain();

        // ---- backpressure fills the FIFO, then release ----
        res_ready = 0; n_acc = 0;
        for (int i = 0; i < 40 && n_acc < 6; i++) begin
            cmd_valid = 1; cmd_a = 8'(8'h10 + n_acc); cmd_b = 8'h00; cmd_op = 3'b110;
            pre = cmd_ready;
            step();
            if (pre) n_acc++;
        end
        chk("t3_accepted",  32'(n_acc), 6);
        cmd_valid = 1; cmd_a = 8'h77;
        for (int i = 0; i < 3; i++) begin
            chk("t3_count_full", 32'(fifo_count), 4);
            chk("t3_ready_low",  32'(cmd_ready), 0);
            chk("t3_lu_a_hold",  32'(lu_a), 32'h11);
            chk("t3_lu_en_low",  32'(lu_en), 0);
            step();
        end
        chk("t3_res_held", 32'(res_y), 32'h10);
        clear_got();
        cmd_a = 8'h16; res_ready = 1;
        for (int i = 0; i < 20; i++) begin
            rec();
            pre = cmd_ready;
            step();
            if (pre && cmd_valid) cmd_valid = 0;
        end
        chk("t3_n", 32'(got_y.size()), 7);
        for (int k = 0; k < 7 && k < got_y.size(); k++)
            chk($sformatf("t3_y%0d", k), 32'(got_y[k]), 32'(8'h10 + k));
        drain();

        // ---- illegal op codes ----
        single(8'h12, 8'h34, 3'b011);
        chk("t4_y",   32'(res_y), 0);
        chk("t4_ill", 32'(res_illegal), 1);
        chk("t4_z",   32'(res_zero), 1);
        chk("t4_op",  32'(res_op), 3);
        drain();
        single(8'hFF, 8'hFF, 3'b100);
        chk("t4b_ill", 32'(res_illegal), 1);
        chk("t4b_z",   32'(res_zero), 1);
        drain();

        // ---- reset mid-operation ----
        res_ready = 0;
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1; cmd_a = 8'(8'h40 + i); cmd_b = 8'h01; cmd_op = 3'b110;
            step();
        end
        cmd_valid = 0;
        chk("t5_count3",  32'(fifo_count), 3);
        chk("t5_pending", 32'(res_valid), 1);
        rst = 1;
        step();
        rst = 0;
        chk("t5_rv",    32'(res_valid), 0);
        chk("t5_count", 32'(fifo_count), 0);
        chk("t5_en",    32'(lu_en), 1);
        chk("t5_ready", 32'(cmd_ready), 1);
        res_ready = 1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_no_stale", 32'(res_valid), 0);
        end

`ifdef ALU_PARITY_EN
        // ---- parity ----
        single(8'h01, 8'h02, 3'b110);
        chk("t6_y0", 32'(res_y), 32'h03);
        chk("t6_p0", 32'(res_parity), 0);
        drain();
        single(8'h01, 8'h00, 3'b110);
        chk("t6_y1", 32'(res_y), 32'h01);
        chk("t6_p1", 32'(res_parity), 1);
        drain();
`endif

        // ---- randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            cmd_valid = ($urandom_range(0, 99) < 60);
            res_ready = ($urandom_range(0, 99) < 65);
            cmd_a     = 8'($urandom);
            cmd_b     = 8'($urandom);
            cmd_op    = 3'($urandom);
            step();
        end
        rst = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
